// File: rtl/uart_tx_arbiter.sv
// Two-requester byte-stream arbiter that feeds one shared UART transmitter.
// Grants are packet-locked; defining UART_TX_ARB_TIMEOUT_EN adds an idle grant timeout.
module uart_tx_arbiter #(
  parameter int unsigned IDLE_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_src,
  output logic       busy,
  output logic       timeout_evt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   rr_q, rr_d;
  logic   xfer_c;
  logic   xfer_last_c;
  logic   tmo_c;

  if ((IDLE_TIMEOUT < 1) || (IDLE_TIMEOUT > 65535)) begin : g_bad_timeout
    $error("uart_tx_arbiter: IDLE_TIMEOUT must be within 1..65535");
  end

  // A byte moves only when the granted stream and the transmitter handshake.
  assign xfer_c      = out_valid & out_ready;
  assign xfer_last_c = xfer_c & ((state_q == S_LOCK1) ? req1_last : req0_last);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: begin
        if (req0_valid && (!req1_valid || !rr_q)) begin
          state_d = S_LOCK0;
        end else if (req1_valid) begin
          state_d = S_LOCK1;
        end
      end
      S_LOCK0: begin
        if (xfer_last_c || tmo_c) begin
          state_d = S_IDLE;
          rr_d    = 1'b1;
        end
      end
      S_LOCK1: begin
        if (xfer_last_c || tmo_c) begin
          state_d = S_IDLE;
          rr_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Granted requester is wired straight through; the other one is stalled.
  always_comb begin
    out_data   = 8'h00;
    out_valid  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    out_src    = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_LOCK0: begin
        out_data   = req0_data;
        out_valid  = req0_valid;
        req0_ready = out_ready;
        busy       = 1'b1;
      end
      S_LOCK1: begin
        out_data   = req1_data;
        out_valid  = req1_valid;
        req1_ready = out_ready;
        out_src    = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             tmo_q;

  // Counts non-transfer cycles while a grant is held.
  always_comb begin
    cnt_inc = cnt_q + CNT_W'(1);
    cnt_d   = '0;
    tmo_c   = 1'b0;
    if ((state_q != S_IDLE) && !xfer_c) begin
      tmo_c = (cnt_inc == CNT_W'(IDLE_TIMEOUT));
      cnt_d = tmo_c ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_c;
    end
  end

  assign timeout_evt = tmo_q;
`else
  assign tmo_c       = 1'b0;
  assign timeout_evt = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter; each cycle drives inputs and compares all outputs.
// Timeout expectations follow UART_TX_ARB_TIMEOUT_EN when it is defined.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] r0_data = 8'h00, r1_data = 8'h00;
  logic       r0_valid = 1'b0, r0_last = 1'b0, r1_valid = 1'b0, r1_last = 1'b0;
  logic       out_ready = 1'b0;
  logic       r0_ready, r1_ready, out_valid, out_src, busy, timeout_evt;
  logic [7:0] out_data;

  int unsigned n_run  = 0;
  int unsigned n_fail = 0;
  logic [7:0]  sent_q[$];

  uart_tx_arbiter #(.IDLE_TIMEOUT(8)) dut (
    .CLK        (clk),
    .RST_N      (rst_n),
    .req0_data  (r0_data),
    .req0_valid (r0_valid),
    .req0_last  (r0_last),
    .req0_ready (r0_ready),
    .req1_data  (r1_data),
    .req1_valid (r1_valid),
    .req1_last  (r1_last),
    .req1_ready (r1_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_src    (out_src),
    .busy       (busy),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Packs {out_data, out_valid, req0_ready, req1_ready, out_src, busy, timeout_evt}.
  function automatic logic [13:0] ev(input logic [7:0] d, input logic v, input logic rd0,
                                     input logic rd1, input logic src, input logic bsy,
                                     input logic tmo);
    return {d, v, rd0, rd1, src, bsy, tmo};
  endfunction

  localparam logic [13:0] Z = 14'h0;

  task automatic cyc(input string tag, input logic rn,
                     input logic v0, input logic [7:0] d0, input logic l0,
                     input logic v1, input logic [7:0] d1, input logic l1,
                     input logic rdy, input logic [13:0] e);
    @(posedge clk);
    #2;
    rst_n    = rn;
    r0_valid = v0; r0_data = d0; r0_last = l0;
    r1_valid = v1; r1_data = d1; r1_last = l1;
    out_ready = rdy;
    #1;
    check(tag, 32'({out_data, out_valid, r0_ready, r1_ready, out_src, busy, timeout_evt}), 32'(e));
    if (out_valid && out_ready) sent_q.push_back(out_data);
  endtask

  initial begin
    logic [31:0] bytes;

    // Reset holds every output low even with both requesters valid.
    cyc("rst0", 0, 1, 8'hAA, 1, 1, 8'hBB, 1, 1, Z);
    cyc("rst1", 0, 1, 8'hAA, 1, 1, 8'hBB, 1, 1, Z);

    // Single req0 packet, then back-to-back packets through an idle gap.
    cyc("a_grant", 1, 1, 8'h11, 0, 0, 8'h00, 0, 1, Z);
    cyc("a_b0",    1, 1, 8'h11, 0, 0, 8'h00, 0, 1, ev(8'h11, 1, 1, 0, 0, 1, 0));
    cyc("a_b1",    1, 1, 8'h22, 0, 0, 8'h00, 0, 1, ev(8'h22, 1, 1, 0, 0, 1, 0));
    cyc("a_b2",    1, 1, 8'h33, 1, 0, 8'h00, 0, 1, ev(8'h33, 1, 1, 0, 0, 1, 0));
    cyc("a_gap",   1, 1, 8'h44, 1, 1, 8'hA1, 1, 1, Z);
    cyc("a_rr1",   1, 1, 8'h44, 1, 1, 8'hA1, 1, 1, ev(8'hA1, 1, 0, 1, 1, 1, 0));
    cyc("a_gap2",  1, 1, 8'h44, 1, 0, 8'h00, 0, 1, Z);
    cyc("a_rr0",   1, 1, 8'h44, 1, 0, 8'h00, 0, 1, ev(8'h44, 1, 1, 0, 0, 1, 0));
    cyc("a_idle",  1, 0, 8'h00, 0, 0, 8'h00, 0, 1, Z);

    // req1 packet with a stalling transmitter while req0 waits with last set.
    sent_q.delete();
    cyc("b_grant", 1, 1, 8'h55, 1, 1, 8'hB0, 0, 1, Z);
    cyc("b_0",     1, 1, 8'h55, 1, 1, 8'hB0, 0, 1, ev(8'hB0, 1, 0, 1, 1, 1, 0));
    cyc("b_1n",    1, 1, 8'h55, 1, 1, 8'hB1, 0, 0, ev(8'hB1, 1, 0, 0, 1, 1, 0));
    cyc("b_1",     1, 1, 8'h55, 1, 1, 8'hB1, 0, 1, ev(8'hB1, 1, 0, 1, 1, 1, 0));
    cyc("b_2n",    1, 1, 8'h55, 1, 1, 8'hB2, 0, 0, ev(8'hB2, 1, 0, 0, 1, 1, 0));
    cyc("b_2",     1, 1, 8'h55, 1, 1, 8'hB2, 0, 1, ev(8'hB2, 1, 0, 1, 1, 1, 0));
    cyc("b_3n",    1, 1, 8'h55, 1, 1, 8'hB3, 1, 0, ev(8'hB3, 1, 0, 0, 1, 1, 0));
    cyc("b_3",     1, 1, 8'h55, 1, 1, 8'hB3, 1, 1, ev(8'hB3, 1, 0, 1, 1, 1, 0));
    check("b_count", 32'(sent_q.size()), 32'd4);
    bytes = '0;
    for (int i = 0; i < 4 && i < sent_q.size(); i++) bytes = {bytes[23:0], sent_q[i]};
    check("b_bytes", bytes, 32'hB0B1B2B3);
    cyc("b_gap",   1, 1, 8'h55, 1, 0, 8'h00, 0, 1, Z);
    cyc("b_r0",    1, 1, 8'h55, 1, 0, 8'h00, 0, 1, ev(8'h55, 1, 1, 0, 0, 1, 0));
    cyc("b_idle",  1, 0, 8'h00, 0, 0, 8'h00, 0, 1, Z);

    // req0 sends one non-last byte then goes quiet while req1 waits.
    cyc("c_grant", 1, 1, 8'h66, 0, 0, 8'h00, 0, 1, Z);
    cyc("c_b0",    1, 1, 8'h66, 0, 1, 8'hC1, 1, 1, ev(8'h66, 1, 1, 0, 0, 1, 0));
    for (int i = 0; i < 8; i++)
      cyc("c_wait", 1, 0, 8'h66, 0, 1, 8'hC1, 1, 1, ev(8'h66, 0, 1, 0, 0, 1, 0));
`ifdef UART_TX_ARB_TIMEOUT_EN
    cyc("c_tmo",   1, 0, 8'h66, 0, 1, 8'hC1, 1, 1, ev(8'h00, 0, 0, 0, 0, 0, 1));
    cyc("c_r1",    1, 0, 8'h66, 0, 1, 8'hC1, 1, 1, ev(8'hC1, 1, 0, 1, 1, 1, 0));
    cyc("c_idle",  1, 0, 8'h00, 0, 0, 8'h00, 0, 1, Z);
`else
    cyc("c_hold",  1, 0, 8'h66, 0, 1, 8'hC1, 1, 1, ev(8'h66, 0, 1, 0, 0, 1, 0));
    cyc("c_last",  1, 1, 8'h67, 1, 1, 8'hC1, 1, 1, ev(8'h67, 1, 1, 0, 0, 1, 0));
    cyc("c_gap",   1, 0, 8'h00, 0, 1, 8'hC1, 1, 1, Z);
    cyc("c_r1",    1, 0, 8'h00, 0, 1, 8'hC1, 1, 1, ev(8'hC1, 1, 0, 1, 1, 1, 0));
    cyc("c_idle",  1, 0, 8'h00, 0, 0, 8'h00, 0, 1, Z);
`endif

    // Reset mid-packet in LOCK1 with the pointer favouring req1 beforehand.
    cyc("d_grant", 1, 1, 8'hF0, 1, 0, 8'h00, 0, 1, Z);
    cyc("d_f0",    1, 1, 8'hF0, 1, 0, 8'h00, 0, 1, ev(8'hF0, 1, 1, 0, 0, 1, 0));
    cyc("d_gap",   1, 0, 8'h00, 0, 1, 8'hD0, 0, 1, Z);
    cyc("d_d0",    1, 0, 8'h00, 0, 1, 8'hD0, 0, 1, ev(8'hD0, 1, 0, 1, 1, 1, 0));
    cyc("d_rst",   0, 1, 8'hE0, 1, 1, 8'hD1, 0, 1, ev(8'hD1, 1, 0, 1, 1, 1, 0));
    cyc("d_post",  1, 1, 8'hE0, 1, 1, 8'hD1, 0, 1, Z);
    cyc("d_r0",    1, 1, 8'hE0, 1, 1, 8'hD1, 0, 1, ev(8'hE0, 1, 1, 0, 0, 1, 0));
    cyc("d_gap2",  1, 0, 8'h00, 0, 1, 8'hD1, 0, 1, Z);
    cyc("d_r1",    1, 0, 8'h00, 0, 1, 8'hD1, 0, 1, ev(8'hD1, 1, 0, 1, 1, 1, 0));
    cyc("d_end",   1, 0, 8'h00, 0, 1, 8'hD2, 1, 1, ev(8'hD2, 1, 0, 1, 1, 1, 0));
    cyc("d_idle",  1, 0, 8'h00, 0, 0, 8'h00, 0, 1, Z);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
